// File: rtl/mpsoc_dbg_pkg.sv
// Shared types and widths for the debug JSP read path (byte FIFO and serializer).
package mpsoc_dbg_pkg;

  localparam int unsigned JSP_HDR_BITS   = 4;
  localparam int unsigned JSP_BYTE_BITS  = 8;
  localparam int unsigned JSP_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } jsp_ser_state_t;

endpackage

// File: rtl/mpsoc_dbg_bytefifo.sv
// 8-deep byte FIFO with a single enable and push/pop select; DATA_OUT shows the oldest byte.
module mpsoc_dbg_bytefifo
  import mpsoc_dbg_pkg::*;
(
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic [JSP_BYTE_BITS-1:0] DATA_IN,
  input  logic                     PUSH_POPn,
  input  logic                     EN,
  output logic [JSP_BYTE_BITS-1:0] DATA_OUT,
  output logic [JSP_HDR_BITS-1:0]  BYTES_AVAIL,
  output logic [JSP_HDR_BITS-1:0]  BYTES_FREE
);

  localparam int unsigned PTR_BITS = $clog2(JSP_FIFO_DEPTH);

  logic [JSP_BYTE_BITS-1:0] mem_q [JSP_FIFO_DEPTH];
  logic [PTR_BITS-1:0]      wr_ptr_q;
  logic [PTR_BITS-1:0]      rd_ptr_q;
  logic [JSP_HDR_BITS-1:0]  cnt_q;
  logic                     push_ok_c;
  logic                     pop_ok_c;

  // Overflowing pushes and underflowing pops are dropped.
  assign push_ok_c = EN &&  PUSH_POPn && (cnt_q != JSP_HDR_BITS'(JSP_FIFO_DEPTH));
  assign pop_ok_c  = EN && !PUSH_POPn && (cnt_q != '0);

  always_ff @(posedge CLK) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
        cnt_q    <= cnt_q + JSP_HDR_BITS'(1);
      end else if (pop_ok_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
        cnt_q    <= cnt_q - JSP_HDR_BITS'(1);
      end
    end
  end

  assign DATA_OUT    = mem_q[rd_ptr_q];
  assign BYTES_AVAIL = cnt_q;
  assign BYTES_FREE  = JSP_HDR_BITS'(JSP_FIFO_DEPTH) - cnt_q;

endmodule

// File: rtl/mpsoc_dbg_jsp_serializer.sv
// JSP read-path drain: shifts a byte-count header then FIFO bytes LSB-first onto TDO.
module mpsoc_dbg_jsp_serializer
  import mpsoc_dbg_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned HDR_BITS  = JSP_HDR_BITS
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic [JSP_BYTE_BITS-1:0] FIFO_DATA,
  input  logic [HDR_BITS-1:0]      FIFO_AVAIL,
  output logic                     FIFO_EN,
  output logic                     FIFO_PUSH_POPn,
  input  logic                     CAPTURE,
  input  logic                     SHIFT,
  output logic                     TDO,
  output logic                     BUSY,
  output logic [HDR_BITS-1:0]      BYTES_SENT,
  output logic                     UNDERRUN
);

  localparam int unsigned BYTE_BITS = JSP_BYTE_BITS;
  localparam logic [HDR_BITS-1:0] MAX_CNT = HDR_BITS'(MAX_BYTES);

  jsp_ser_state_t        state_q,    state_d;
  logic [BYTE_BITS-1:0]  shreg_q,    shreg_d;
  logic [2:0]            bit_cnt_q,  bit_cnt_d;
  logic [HDR_BITS-1:0]   snap_q,     snap_d;
  logic [HDR_BITS-1:0]   sent_q,     sent_d;
  logic                  underrun_q, underrun_d;
  logic                  tdo_q,      tdo_d;
  logic                  busy_q,     busy_d;
  logic                  reload_c;
  logic                  fifo_en_c;
  logic [HDR_BITS-1:0]   snap_capture_c;

  assign snap_capture_c = (FIFO_AVAIL > MAX_CNT) ? MAX_CNT : FIFO_AVAIL;

  // Next-state: CAPTURE wins over SHIFT; the pop shares the cycle of the last shifted bit.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    snap_d     = snap_q;
    sent_d     = sent_q;
    underrun_d = underrun_q;
    reload_c   = 1'b0;
    fifo_en_c  = 1'b0;

    if (CAPTURE) begin
      snap_d     = snap_capture_c;
      shreg_d    = BYTE_BITS'(snap_capture_c);
      bit_cnt_d  = '0;
      sent_d     = '0;
      underrun_d = 1'b0;
      state_d    = HDR;
    end else if (SHIFT && ((state_q == HDR) || (state_q == DATA))) begin
      shreg_d   = shreg_q >> 1;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if ((state_q == HDR) && (bit_cnt_q == 3'(HDR_BITS - 1))) begin
        if (snap_q == '0) state_d = DONE;
        else              reload_c = 1'b1;
      end else if ((state_q == DATA) && (bit_cnt_q == 3'(BYTE_BITS - 1))) begin
        if (sent_q == snap_q) state_d = DONE;
        else                  reload_c = 1'b1;
      end
      if (reload_c) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        sent_d    = sent_q + HDR_BITS'(1);
        // An empty FIFO still consumes a byte slot so the host sees the promised count.
        if (FIFO_AVAIL == '0) begin
          shreg_d    = '0;
          underrun_d = 1'b1;
        end else begin
          shreg_d   = FIFO_DATA;
          fifo_en_c = 1'b1;
        end
      end
    end

    busy_d = (state_d == HDR) || (state_d == DATA);
    tdo_d  = busy_d && shreg_d[0];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      snap_q     <= '0;
      sent_q     <= '0;
      underrun_q <= 1'b0;
      tdo_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      snap_q     <= snap_d;
      sent_q     <= sent_d;
      underrun_q <= underrun_d;
      tdo_q      <= tdo_d;
      busy_q     <= busy_d;
    end
  end

  assign FIFO_EN        = fifo_en_c;
  assign FIFO_PUSH_POPn = 1'b0;
  assign TDO            = tdo_q;
  assign BUSY           = busy_q;
  assign BYTES_SENT     = sent_q;
  assign UNDERRUN       = underrun_q;

endmodule

// File: tb/tb_mpsoc_dbg_jsp_serializer.sv
// Bench: two FIFO+serializer stacks (MAX_BYTES 8 and 2) checked every cycle against a positional model.
module tb_mpsoc_dbg_jsp_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       capture = 1'b0, shift = 1'b0, push8 = 1'b0, push2 = 1'b0, frc = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] f8_dout, f2_dout;
  logic [3:0] f8_avail, f2_avail, f8_free, f2_free;
  logic       s8_en, s2_en, s8_pp, s2_pp;
  logic       tdo8, tdo2, busy8, busy2, und8, und2;
  logic [3:0] sent8, sent2;
  logic [3:0] eff8, eff2;

  assign eff8 = frc ? 4'd0 : f8_avail;
  assign eff2 = frc ? 4'd0 : f2_avail;

  mpsoc_dbg_bytefifo f8 (
    .CLK(clk), .RSTn(rst_n), .DATA_IN(din), .PUSH_POPn(push8 | s8_pp), .EN(push8 | s8_en),
    .DATA_OUT(f8_dout), .BYTES_AVAIL(f8_avail), .BYTES_FREE(f8_free));
  mpsoc_dbg_bytefifo f2 (
    .CLK(clk), .RSTn(rst_n), .DATA_IN(din), .PUSH_POPn(push2 | s2_pp), .EN(push2 | s2_en),
    .DATA_OUT(f2_dout), .BYTES_AVAIL(f2_avail), .BYTES_FREE(f2_free));

  mpsoc_dbg_jsp_serializer #(.MAX_BYTES(8), .HDR_BITS(4)) dut8 (
    .CLK(clk), .RSTn(rst_n), .FIFO_DATA(f8_dout), .FIFO_AVAIL(eff8), .FIFO_EN(s8_en),
    .FIFO_PUSH_POPn(s8_pp), .CAPTURE(capture), .SHIFT(shift), .TDO(tdo8), .BUSY(busy8),
    .BYTES_SENT(sent8), .UNDERRUN(und8));
  mpsoc_dbg_jsp_serializer #(.MAX_BYTES(2), .HDR_BITS(4)) dut2 (
    .CLK(clk), .RSTn(rst_n), .FIFO_DATA(f2_dout), .FIFO_AVAIL(eff2), .FIFO_EN(s2_en),
    .FIFO_PUSH_POPn(s2_pp), .CAPTURE(capture), .SHIFT(shift), .TDO(tdo2), .BUSY(busy2),
    .BYTES_SENT(sent2), .UNDERRUN(und2));

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per stack, FIFO contents plus position (shifts since CAPTURE) within the scan.
  logic [7:0] mbuf  [2][8];
  int         mcnt  [2];
  int         mpos  [2];
  int         msnap [2];
  int         msent [2];
  bit         mact  [2];
  bit         munder[2];
  logic [7:0] mbyte [2];

  function automatic int max_of(int s);
    return (s == 0) ? 8 : 2;
  endfunction

  function automatic int eff_avail(int s);
    return frc ? 0 : mcnt[s];
  endfunction

  function automatic bit m_busy(int s);
    return mact[s] && (mpos[s] < 4 + 8 * msnap[s]);
  endfunction

  function automatic bit m_tdo(int s);
    if (!m_busy(s)) return 1'b0;
    if (mpos[s] < 4) return 1'(msnap[s] >> mpos[s]);
    return mbyte[s][(mpos[s] - 4) % 8];
  endfunction

  function automatic bit m_reload(int s);
    int n;
    n = mpos[s] + 1;
    return m_busy(s) && (n >= 4) && (((n - 4) % 8) == 0) && (((n - 4) / 8) < msnap[s]);
  endfunction

  initial begin
    for (int s = 0; s < 2; s++) begin
      mcnt[s] = 0; mpos[s] = 0; msnap[s] = 0; msent[s] = 0;
      mact[s] = 1'b0; munder[s] = 1'b0; mbyte[s] = 8'h00;
      for (int j = 0; j < 8; j++) mbuf[s][j] = 8'h00;
    end
  end

  // Compare outputs mid-cycle, then advance the model to the coming clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        int  ea;
        bit  rl;
        bit  psh;
        ea  = eff_avail(s);
        rl  = !capture && shift && m_reload(s);
        psh = (s == 0) ? push8 : push2;
        chk($sformatf("tdo%0d", max_of(s)),      int'((s == 0) ? tdo8 : tdo2), int'(m_tdo(s)));
        chk($sformatf("busy%0d", max_of(s)),     int'((s == 0) ? busy8 : busy2), int'(m_busy(s)));
        chk($sformatf("sent%0d", max_of(s)),     int'((s == 0) ? sent8 : sent2), msent[s]);
        chk($sformatf("underrun%0d", max_of(s)), int'((s == 0) ? und8 : und2), int'(munder[s]));
        chk($sformatf("fifo_en%0d", max_of(s)),  int'((s == 0) ? s8_en : s2_en), int'(rl && (ea > 0)));
        chk($sformatf("avail%0d", max_of(s)),    int'((s == 0) ? f8_avail : f2_avail), mcnt[s]);
        if (capture) begin
          mact[s] = 1'b1; mpos[s] = 0; msent[s] = 0; munder[s] = 1'b0;
          msnap[s] = (ea > max_of(s)) ? max_of(s) : ea;
        end else if (shift && m_busy(s)) begin
          if (rl) begin
            msent[s]++;
            if (ea > 0) begin
              mbyte[s] = mbuf[s][0];
              for (int j = 0; j < 7; j++) mbuf[s][j] = mbuf[s][j + 1];
              mcnt[s]--;
            end else begin
              mbyte[s]  = 8'h00;
              munder[s] = 1'b1;
            end
          end
          mpos[s]++;
        end
        if (psh && mcnt[s] < 8) begin
          mbuf[s][mcnt[s]] = din;
          mcnt[s]++;
        end
      end
    end
  end

  task automatic cyc(input bit cap, input bit sh, input bit p8, input bit p2,
                     input logic [7:0] d, input bit f);
    @(posedge clk);
    #1;
    capture = cap; shift = sh; push8 = p8; push2 = p2; din = d; frc = f;
    @(negedge clk);
  endtask

  logic [67:0] rec;
  int          en8, en2;

  initial begin
    #12;
    @(negedge clk);
    chk("rst_tdo",      int'(tdo8),  0);
    chk("rst_busy",     int'(busy8), 0);
    chk("rst_sent",     int'(sent8), 0);
    chk("rst_underrun", int'(und8),  0);
    chk("rst_fifo_en",  int'(s8_en), 0);
    // SHIFT during reset and before any CAPTURE must be ignored.
    @(posedge clk); #1; rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (3) cyc(0, 1, 0, 0, 8'h00, 0);
    chk("noncap_busy", int'(busy8), 0);

    // Empty FIFO: header of zero, then DONE after four shifts.
    cyc(1, 0, 0, 0, 8'h00, 0);
    rec = '0; en8 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0, 8'h00, 0);
      rec[i] = tdo8; en8 += int'(s8_en);
      if (i == 3) chk("t1_busy_hdr", int'(busy8), 1);
      if (i == 4) chk("t1_busy_done", int'(busy8), 0);
    end
    chk("t1_stream", int'(rec[5:0]), 0);
    chk("t1_pops", en8, 0);
    chk("t1_sent", int'(sent8), 0);

    // Single byte 0xA5.
    cyc(0, 0, 1, 0, 8'hA5, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    rec = '0; en8 = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 0, 0, 8'h00, 0);
      rec[i] = tdo8; en8 += int'(s8_en);
      if (i == 3) chk("t2_pop_at_4th", int'(s8_en), 1);
    end
    cyc(0, 0, 0, 0, 8'h00, 0);
    chk("t2_stream", int'(rec[11:0]), 12'hA51);
    chk("t2_pops", en8, 1);
    chk("t2_sent", int'(sent8), 1);
    chk("t2_avail", int'(f8_avail), 0);

    // MAX_BYTES=2 with five bytes queued.
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'(8'h11 + i), 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    rec = '0; en2 = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0, 0, 8'h00, 0);
      rec[i] = tdo2; en2 += int'(s2_en);
    end
    cyc(0, 0, 0, 0, 8'h00, 0);
    chk("t4_stream", int'(rec[19:0]), 20'h12112);
    chk("t4_pops", en2, 2);
    chk("t4_sent", int'(sent2), 2);
    chk("t4_avail", int'(f2_avail), 3);
    chk("t4_busy", int'(busy2), 0);
    for (int k = 0; k < 2; k++) begin
      cyc(1, 0, 0, 0, 8'h00, 0);
      repeat (20) cyc(0, 1, 0, 0, 8'h00, 0);
    end
    chk("t4_drained", int'(f2_avail), 0);

    // Full FIFO 0x01..0x08: header 8 then all bytes in push order.
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 8'(i + 1), 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    rec = '0; en8 = 0;
    for (int i = 0; i < 68; i++) begin
      cyc(0, 1, 0, 0, 8'h00, 0);
      rec[i] = tdo8; en8 += int'(s8_en);
    end
    chk("t3_busy_last", int'(busy8), 1);
    cyc(0, 0, 0, 0, 8'h00, 0);
    chk("t3_stream_lo", int'(rec[35:0] >> 4), 32'h04030201);
    chk("t3_stream_hi", int'(rec[67:36]), 32'h08070605);
    chk("t3_header", int'(rec[3:0]), 8);
    chk("t3_pops", en8, 8);
    chk("t3_busy_end", int'(busy8), 0);

    // Re-CAPTURE after three data bits: new header counts only what remains.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 8'(8'h21 + i), 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    repeat (7) cyc(0, 1, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    rec = '0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 0, 0, 8'h00, 0);
      rec[i] = tdo8;
    end
    chk("t5_stream", int'(rec[11:0]), 12'h222);
    repeat (8) cyc(0, 1, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    repeat (12) cyc(0, 1, 0, 0, 8'h00, 0);
    chk("t5_drained", int'(f8_avail), 0);

    // AVAIL forced to zero at the reload: zeros shipped, UNDERRUN sticky.
    cyc(0, 0, 1, 0, 8'h5C, 0);
    cyc(1, 0, 0, 0, 8'h00, 0);
    repeat (3) cyc(0, 1, 0, 0, 8'h00, 0);
    cyc(0, 1, 0, 0, 8'h00, 1);
    chk("t6_no_pop", int'(s8_en), 0);
    rec = '0; en8 = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0, 8'h00, 1);
      rec[i] = tdo8; en8 += int'(s8_en);
    end
    cyc(0, 0, 0, 0, 8'h00, 1);
    chk("t6_zeros", int'(rec[7:0]), 0);
    chk("t6_pops", en8, 0);
    chk("t6_underrun", int'(und8), 1);
    chk("t6_sent", int'(sent8), 1);
    chk("t6_avail", int'(f8_avail), 1);
    cyc(1, 0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 0, 8'h00, 0);
    chk("t6_underrun_clr", int'(und8), 0);
    repeat (12) cyc(0, 1, 0, 0, 8'h00, 0);
    chk("t6_drained", int'(f8_avail), 0);

    // Randomized traffic; the per-cycle model compare covers it.
    begin
      bit f;
      f = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        bit c, sh, p8, p2;
        c  = ($urandom % 40) == 0;
        sh = ($urandom % 10) < 7;
        p8 = !sh && (mcnt[0] < 8) && (($urandom % 3) == 0);
        p2 = !sh && (mcnt[1] < 8) && (($urandom % 3) == 0);
        if (($urandom % 150) == 0) f = !f;
        cyc(c, sh, p8, p2, 8'($urandom), f);
      end
    end
    cyc(0, 0, 0, 0, 8'h00, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
